// File: rtl/falling_piece_pkg.sv
// Shared types and default constants for the falling-piece controller.
package falling_piece_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPAWN,
    ST_FALL,
    ST_LOCK,
    ST_OVER
  } state_e;

  localparam int unsigned DEF_COLS     = 10;
  localparam int unsigned DEF_ROWS     = 20;
  localparam int unsigned DEF_COORD_W  = 5;
  localparam int unsigned DEF_SPAWN_X  = 4;
  localparam int unsigned DEF_TICK_DIV = 50_000_000;
  localparam int unsigned DEF_FAST_DIV = 5_000_000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/falling_piece_if.sv
// Controller-side bundle: run/move inputs, board probe, piece position and lock strobe.
interface falling_piece_if
  import falling_piece_pkg::*;
#(
  parameter int unsigned COORD_W = DEF_COORD_W
) ();

  logic               en;
  logic               move_left;
  logic               move_right;
  logic               soft_drop;
  logic [COORD_W-1:0] probe_x;
  logic [COORD_W-1:0] probe_y;
  logic               probe_hit;
  logic [COORD_W-1:0] current_x;
  logic [COORD_W-1:0] current_y;
  logic               tick;
  logic               lock_valid;
  logic [COORD_W-1:0] lock_x;
  logic [COORD_W-1:0] lock_y;
  logic               game_over;

  modport master (
    input  en, move_left, move_right, soft_drop, probe_hit,
    output probe_x, probe_y, current_x, current_y, tick,
           lock_valid, lock_x, lock_y, game_over
  );

  modport slave (
    output en, move_left, move_right, soft_drop, probe_hit,
    input  probe_x, probe_y, current_x, current_y, tick,
           lock_valid, lock_x, lock_y, game_over
  );

endinterface

// File: rtl/gravity_tick_gen.sv
// Gravity divider: counts 0..DIV-1 while running and pulses a registered tick on wrap.
module gravity_tick_gen
  import falling_piece_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter int unsigned FAST_DIV = DEF_FAST_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  input  logic fast,
  output logic tick
);

  localparam int unsigned MAX_DIV = max_u(TICK_DIV, FAST_DIV);
  localparam int unsigned CNT_W   = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_m1;

  assign div_m1 = fast ? CNT_W'(FAST_DIV - 1) : CNT_W'(TICK_DIV - 1);

  // A tick interrupted by a pause is re-armed by parking the count at the top.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!run) begin
      tick <= 1'b0;
      if (tick) cnt <= div_m1;
    end else if (cnt >= div_m1) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CNT_W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/falling_piece_ctrl.sv
// Single-cell falling-piece controller: spawn, gravity, lateral moves, lock and game over.
// Build option SOFT_DROP_EN: when defined, soft_drop selects the fast gravity divider.
module falling_piece_ctrl
  import falling_piece_pkg::*;
#(
  parameter int unsigned COLS     = DEF_COLS,
  parameter int unsigned ROWS     = DEF_ROWS,
  parameter int unsigned COORD_W  = DEF_COORD_W,
  parameter int unsigned SPAWN_X  = DEF_SPAWN_X,
  parameter int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter int unsigned FAST_DIV = DEF_FAST_DIV
) (
  input  logic              clk,
  input  logic              rst,
  falling_piece_if.master   bus
);

  localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(COLS - 1);
  localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(ROWS - 1);
  localparam logic [COORD_W-1:0] X_SPAWN = COORD_W'(SPAWN_X);

  state_e             state;
  logic [COORD_W-1:0] cur_x;
  logic [COORD_W-1:0] cur_y;
  logic [COORD_W-1:0] lock_x;
  logic [COORD_W-1:0] lock_y;
  logic               lock_valid;
  logic               game_over;
  logic               tick;
  logic               fast;
  logic               active;
  logic               step;
  logic               go_left;
  logic               go_right;
  logic [COORD_W-1:0] probe_x;
  logic [COORD_W-1:0] probe_y;

`ifdef SOFT_DROP_EN
  assign fast = bus.soft_drop;
`else
  logic unused_soft_drop;
  assign unused_soft_drop = bus.soft_drop;
  assign fast             = 1'b0;
`endif

  gravity_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .FAST_DIV (FAST_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .run   (active),
    .clear (state != ST_FALL),
    .fast  (fast),
    .tick  (tick)
  );

  // One probe per cycle: spawn cell, then gravity, then a single-direction move.
  always_comb begin
    active   = bus.en && (state == ST_FALL);
    step     = active && tick;
    go_left  = active && !tick && bus.move_left && !bus.move_right && (cur_x != '0);
    go_right = active && !tick && bus.move_right && !bus.move_left && (cur_x != X_MAX);
    probe_x  = cur_x;
    probe_y  = cur_y;
    if (state == ST_SPAWN) begin
      probe_x = X_SPAWN;
      probe_y = '0;
    end else if (step) begin
      if (cur_y != Y_MAX) probe_y = cur_y + COORD_W'(1);
    end else if (go_left) begin
      probe_x = cur_x - COORD_W'(1);
    end else if (go_right) begin
      probe_x = cur_x + COORD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cur_x      <= X_SPAWN;
      cur_y      <= '0;
      lock_valid <= 1'b0;
      lock_x     <= '0;
      lock_y     <= '0;
      game_over  <= 1'b0;
    end else begin
      lock_valid <= 1'b0;
      if (bus.en) begin
        case (state)
          ST_IDLE:  state <= ST_SPAWN;
          ST_SPAWN: begin
            if (bus.probe_hit) begin
              state     <= ST_OVER;
              game_over <= 1'b1;
            end else begin
              cur_x <= X_SPAWN;
              cur_y <= '0;
              state <= ST_FALL;
            end
          end
          ST_FALL: begin
            if (step) begin
              if ((cur_y == Y_MAX) || bus.probe_hit) begin
                state      <= ST_LOCK;
                lock_valid <= 1'b1;
                lock_x     <= cur_x;
                lock_y     <= cur_y;
              end else begin
                cur_y <= cur_y + COORD_W'(1);
              end
            end else if (go_left && !bus.probe_hit) begin
              cur_x <= cur_x - COORD_W'(1);
            end else if (go_right && !bus.probe_hit) begin
              cur_x <= cur_x + COORD_W'(1);
            end
          end
          ST_LOCK: state <= ST_SPAWN;
          ST_OVER: state <= ST_OVER;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.probe_x    = probe_x;
  assign bus.probe_y    = probe_y;
  assign bus.current_x  = cur_x;
  assign bus.current_y  = cur_y;
  assign bus.tick       = tick;
  assign bus.lock_valid = lock_valid;
  assign bus.lock_x     = lock_x;
  assign bus.lock_y     = lock_y;
  assign bus.game_over  = game_over;

endmodule
